// File: rtl/mc_store_pkg.sv
// mc_store_pkg: shared types and constants for the microcode control-store loader.
//   - state_t         : loader FSM state enum
//   - MC_ADDR_W       : control-store address width
//   - MC_DATA_W       : control-store word width
//   - MC_BYTES_PER_WORD : host bytes packed per store word
//   - PIN_INACTIVE    : idle level of the active-low store pins
package mc_store_pkg;

    localparam int unsigned MC_ADDR_W         = 8;
    localparam int unsigned MC_DATA_W         = 64;
    localparam int unsigned MC_BYTES_PER_WORD = 8;

    localparam logic PIN_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_VERIFY,
        S_DONE
    } state_t;

endpackage

// File: rtl/mc_byte_packer.sv
// mc_byte_packer: collects host bytes into one little-endian store word.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_accept       : a byte is taken this cycle
//   i_clear        : restart packing at byte 0 (new load)
//   i_byte         : host byte
//   o_word         : packed word (first byte in [7:0])
//   o_word_full    : the byte accepted this cycle completes the word
module mc_byte_packer
    import mc_store_pkg::*;
#(
    parameter int unsigned DATA_W = MC_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_accept,
    input  logic              i_clear,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_full
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_word;

    // Shifting in from the top leaves the first byte at [7:0] once the
    // word is complete.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            if (i_clear)
                r_cnt <= '0;
            else if (i_accept)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            if (i_accept)
                r_word <= {i_byte, r_word[DATA_W-1:8]};
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_accept && (r_cnt == LAST);

endmodule

// File: rtl/mc_store_loader.sv
// mc_store_loader: packs host bytes into 64-bit words and writes them to the
// microcode control store at consecutive addresses, optionally reading each
// word back for comparison.
// Optional feature macro: MC_LOADER_VERIFY_EN (readback verify state/comparator).
// Ports:
//   clk, _reset              : clock, asynchronous active-low reset
//   start, base_addr, word_count : load request (sampled only when idle)
//   byte_valid, byte_data, byte_ready : host byte channel
//   busy, done               : load in progress / end-of-load pulse
//   verify_err, err_addr     : sticky readback mismatch flag and first bad address
//   _mc_cs, _mc_oe, _mc_w    : active-low store control pins
//   mc_addr, mc_wdata, mc_rdata : store address / write data / read data
module mc_store_loader
    import mc_store_pkg::*;
#(
    parameter int unsigned ADDR_W  = MC_ADDR_W,
    parameter int unsigned DATA_W  = MC_DATA_W,
    parameter int unsigned W_PULSE = 2,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              _mc_cs,
    output logic              _mc_oe,
    output logic              _mc_w,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam int unsigned TMR_MAX = (W_PULSE > RD_WAIT + 1) ? W_PULSE : RD_WAIT + 1;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t              r_state, w_nxt;
    logic [TMR_W-1:0]    r_tmr;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_cs_n, r_w_n, r_byte_ready, r_busy, r_done;
    logic                w_accept, w_word_full, w_start, w_advance, w_last_word;

    assign w_accept    = byte_valid & r_byte_ready;
    assign w_start     = (r_state == S_IDLE) && start && (word_count != '0);
    assign w_last_word = (r_count == (ADDR_W+1)'(1));

    mc_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .i_clk       (clk),
        .i_rst_n     (_reset),
        .i_accept    (w_accept),
        .i_clear     (w_start),
        .i_byte      (byte_data),
        .o_word      (mc_wdata),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_nxt     = r_state;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE:    if (start) w_nxt = (word_count == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (w_word_full) w_nxt = S_SETUP;
            S_SETUP:   w_nxt = S_STROBE;
            S_STROBE:  if (r_tmr == '0) w_nxt = S_HOLD;
`ifdef MC_LOADER_VERIFY_EN
            S_HOLD:    w_nxt = S_VERIFY;
            S_VERIFY:  if (r_tmr == '0) w_advance = 1'b1;
`else
            S_HOLD:    w_advance = 1'b1;
            S_VERIFY:  w_nxt = S_IDLE;
`endif
            S_DONE:    w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
        endcase
        if (w_advance)
            w_nxt = w_last_word ? S_DONE : S_COLLECT;
    end

    // Pin and status registers are loaded from the next state so every
    // output is a flop whose value matches the state it belongs to.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state      <= S_IDLE;
            r_cs_n       <= PIN_INACTIVE;
            r_w_n        <= PIN_INACTIVE;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_cs_n       <= !(w_nxt inside {S_SETUP, S_STROBE, S_HOLD, S_VERIFY});
            r_w_n        <= (w_nxt == S_STROBE) ? ~PIN_INACTIVE : PIN_INACTIVE;
            r_byte_ready <= (w_nxt == S_COLLECT);
            r_busy       <= (w_nxt != S_IDLE);
            r_done       <= (w_nxt == S_DONE);
        end
    end

    // One down-counter times both the write strobe and the readback wait.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_tmr   <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            if (w_nxt == S_STROBE && r_state != S_STROBE)
                r_tmr <= TMR_W'(W_PULSE - 1);
            else if (w_nxt == S_VERIFY && r_state != S_VERIFY)
                r_tmr <= TMR_W'(RD_WAIT);
            else if (r_tmr != '0)
                r_tmr <= r_tmr - TMR_W'(1);

            if (w_start) begin
                r_addr  <= base_addr;
                r_count <= word_count;
            end else if (w_advance) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count - (ADDR_W+1)'(1);
            end
        end
    end

`ifdef MC_LOADER_VERIFY_EN
    logic              r_oe_n, r_verify_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic              w_mismatch;

    assign w_mismatch = (r_state == S_VERIFY) && (r_tmr == '0) && (mc_rdata != mc_wdata);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_oe_n       <= PIN_INACTIVE;
            r_verify_err <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_oe_n <= (w_nxt == S_VERIFY) ? ~PIN_INACTIVE : PIN_INACTIVE;
            if (w_start) begin
                r_verify_err <= 1'b0;
                r_err_addr   <= '0;
            end else if (w_mismatch && !r_verify_err) begin
                r_verify_err <= 1'b1;
                r_err_addr   <= r_addr;
            end
        end
    end

    assign _mc_oe     = r_oe_n;
    assign verify_err = r_verify_err;
    assign err_addr   = r_err_addr;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^mc_rdata;

    assign _mc_oe     = PIN_INACTIVE;
    assign verify_err = 1'b0;
    assign err_addr   = '0;
`endif

    assign _mc_cs     = r_cs_n;
    assign _mc_w      = r_w_n;
    assign mc_addr    = r_addr;
    assign byte_ready = r_byte_ready;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_mc_store_loader.sv
module tb_mc_store_loader;

    localparam int W_PULSE = 2;

    logic        clk = 1'b0;
    logic        _reset, start, byte_valid;
    logic [7:0]  base_addr, byte_data;
    logic [8:0]  word_count;
    logic        byte_ready, busy, done, verify_err, _mc_cs, _mc_oe, _mc_w;
    logic [7:0]  err_addr, mc_addr;
    logic [63:0] mc_wdata, mc_rdata;

    always #5 clk = ~clk;

    mc_store_loader dut (
        .clk        (clk),
        ._reset     (_reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err),
        .err_addr   (err_addr),
        ._mc_cs     (_mc_cs),
        ._mc_oe     (_mc_oe),
        ._mc_w      (_mc_w),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_rdata   (mc_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Store model: writes land on the falling edge of the write strobe.
    bit          mon_en   = 1'b0;
    bit          fault_en = 1'b0;
    logic [63:0] mem [0:255];
    logic [7:0]  wa [0:1023];
    logic [63:0] wd [0:1023];
    int          wr_n = 0;

    always @(negedge _mc_w) begin
        if (mon_en) begin
            wa[wr_n] = mc_addr;
            wd[wr_n] = mc_wdata;
            mem[mc_addr] = (fault_en && mc_addr == 8'h21) ? (mc_wdata & ~64'h20) : mc_wdata;
            wr_n = wr_n + 1;
        end
    end

    assign mc_rdata = _mc_oe ? 64'h0 : mem[mc_addr];

    // Pin activity and write-cycle timing monitor.
    int          cs_cnt = 0, oe_cnt = 0, done_cnt = 0, low_cnt = 0, last_pulse = 0, stab_cnt = 0;
    bit          prev_w = 1'b1, prev_cs = 1'b1;
    logic [7:0]  prev_a, pulse_a;
    logic [63:0] prev_d, pulse_d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!_mc_cs) cs_cnt = cs_cnt + 1;
            if (!_mc_oe) oe_cnt = oe_cnt + 1;
            if (done)    done_cnt = done_cnt + 1;
            if (!_mc_w && prev_w) begin
                if (mc_addr !== prev_a || mc_wdata !== prev_d || prev_cs !== 1'b0 || _mc_cs !== 1'b0)
                    stab_cnt = stab_cnt + 1;
                pulse_a = mc_addr;
                pulse_d = mc_wdata;
            end
            if (_mc_w && !prev_w) begin
                if (mc_addr !== pulse_a || mc_wdata !== pulse_d || _mc_cs !== 1'b0)
                    stab_cnt = stab_cnt + 1;
                last_pulse = low_cnt;
                low_cnt = 0;
            end
            if (!_mc_w) low_cnt = low_cnt + 1;
            prev_w  = _mc_w;
            prev_cs = _mc_cs;
            prev_a  = mc_addr;
            prev_d  = mc_wdata;
        end
    end

    // Results of the most recent load.
    bit          timed_out;
    int          done_delta, n_wr, w_base, stall_cs;
    logic [7:0]  exp_a [0:15];
    logic [63:0] exp_d [0:15];

    // Drives one complete load; mode 0 random bytes, 1 bytes 1..8, 2 all ones.
    task automatic do_load(input logic [7:0] base, input int cnt, input int mode,
                           input int stall_at, input int stall_len, input int poke_at, input bit gaps);
        int          d0, t, g, cs0;
        logic [7:0]  b;
        logic [63:0] data;
        timed_out = 1'b0;
        stall_cs  = 0;
        d0        = done_cnt;
        w_base    = wr_n;
        start = 1'b1; base_addr = base; word_count = 9'(cnt);
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom); word_count = 9'($urandom_range(0, 256));
        for (int w = 0; w < cnt; w++) begin
            data = '0;
            for (int i = 0; i < 8; i++) begin
                g = w * 8 + i;
                b = (mode == 1) ? 8'(i + 1) : (mode == 2) ? 8'hFF : 8'($urandom);
                data = data | (64'(b) << (8 * i));
                if (g == stall_at) begin
                    cs0 = cs_cnt;
                    repeat (stall_len) @(negedge clk);
                    stall_cs = cs_cnt - cs0;
                end
                if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                if (g == poke_at) begin
                    start = 1'b1; base_addr = 8'h55; word_count = 9'd0;
                end
                byte_valid = 1'b1;
                byte_data  = b;
                t = 0;
                while (!byte_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!byte_ready) timed_out = 1'b1;
                @(negedge clk);
                byte_valid = 1'b0;
                start      = 1'b0;
            end
            exp_a[w] = base + 8'(w);
            exp_d[w] = data;
        end
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) timed_out = 1'b1;
        repeat (2) @(negedge clk);
        done_delta = done_cnt - d0;
        n_wr       = wr_n - w_base;
    endtask

    task automatic test_reset();
        int t, cs0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({_mc_cs, _mc_oe, _mc_w, byte_ready, busy, done, verify_err} !== 7'b1110000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, expected %b",
                     {_mc_cs, _mc_oe, _mc_w, byte_ready, busy, done, verify_err}, 7'b1110000);
        end
        n_vec++;
        if ({mc_addr, err_addr, mc_wdata} !== 80'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h, expected 0", {mc_addr, err_addr, mc_wdata});
        end
        _reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 8'h40; word_count = 9'd2;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_data = 8'(8'hA0 + i);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        t = 0;
        while (_mc_w && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (_mc_w !== 1'b0) begin
            n_err++;
            $display("FAIL reach_strobe: _mc_w got %b, expected 0", _mc_w);
        end
        #1 _reset = 1'b0;
        #1;
        n_vec++;
        if ({_mc_cs, _mc_oe, _mc_w, byte_ready, busy, done, verify_err} !== 7'b1110000) begin
            n_err++;
            $display("FAIL midload_reset_ctrl: got %b, expected %b",
                     {_mc_cs, _mc_oe, _mc_w, byte_ready, busy, done, verify_err}, 7'b1110000);
        end
        n_vec++;
        if ({mc_addr, err_addr, mc_wdata} !== 80'h0) begin
            n_err++;
            $display("FAIL midload_reset_data: got %h, expected 0", {mc_addr, err_addr, mc_wdata});
        end
        @(negedge clk);
        _reset = 1'b1;
        cs0 = cs_cnt;
        repeat (5) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || cs_cnt != cs0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b cs_cycles=%0d, expected busy=0 cs_cycles=0", busy, cs_cnt - cs0);
        end
    endtask

    task automatic test_single_word();
        int s0 = stab_cnt;
        do_load(8'h10, 1, 1, -1, 0, -1, 1'b0);
        n_vec++;
        if (timed_out || n_wr != 1 || done_delta != 1) begin
            n_err++;
            $display("FAIL single_count: writes=%0d done=%0d timeout=%0d, expected 1 1 0", n_wr, done_delta, timed_out);
        end
        n_vec++;
        if (wa[w_base] !== 8'h10 || wd[w_base] !== 64'h0807060504030201) begin
            n_err++;
            $display("FAIL single_word: got %h/%h, expected 10/0807060504030201", wa[w_base], wd[w_base]);
        end
        n_vec++;
        if (last_pulse != W_PULSE) begin
            n_err++;
            $display("FAIL strobe_width: got %0d, expected %0d", last_pulse, W_PULSE);
        end
        n_vec++;
        if (stab_cnt != s0) begin
            n_err++;
            $display("FAIL addr_data_setup_hold: got %0d violations, expected 0", stab_cnt - s0);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy_end: got %b, expected 0", busy);
        end
    endtask

    task automatic test_wraparound();
        logic [7:0] want [0:2];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        do_load(8'hFE, 3, 0, -1, 0, -1, 1'b0);
        n_vec++;
        if (timed_out || n_wr != 3 || done_delta != 1) begin
            n_err++;
            $display("FAIL wrap_count: writes=%0d done=%0d timeout=%0d, expected 3 1 0", n_wr, done_delta, timed_out);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (wa[w_base + i] !== want[i] || wd[w_base + i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL wrap_word%0d: got %h/%h, expected %h/%h", i, wa[w_base + i], wd[w_base + i], want[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_host_stall();
        do_load(8'h30, 1, 0, 3, 20, -1, 1'b0);
        n_vec++;
        if (stall_cs != 0) begin
            n_err++;
            $display("FAIL stall_pins: got %0d cs cycles, expected 0", stall_cs);
        end
        n_vec++;
        if (timed_out || n_wr != 1 || wa[w_base] !== 8'h30 || wd[w_base] !== exp_d[0] || done_delta != 1) begin
            n_err++;
            $display("FAIL stall_word: got n=%0d %h/%h done=%0d, expected 1 30/%h 1", n_wr, wa[w_base], wd[w_base], done_delta, exp_d[0]);
        end
    endtask

    task automatic test_zero_count();
        int cs0 = cs_cnt;
        int w0  = wr_n;
        start = 1'b1; base_addr = 8'h77; word_count = 9'd0;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_done: done=%b busy=%b, expected 1 1", done, busy);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_idle: done=%b busy=%b, expected 0 0", done, busy);
        end
        n_vec++;
        if (cs_cnt != cs0 || wr_n != w0) begin
            n_err++;
            $display("FAIL zero_no_access: cs=%0d writes=%0d, expected 0 0", cs_cnt - cs0, wr_n - w0);
        end
    endtask

    task automatic test_busy_start();
        do_load(8'h60, 2, 0, -1, 0, 8, 1'b0);
        n_vec++;
        if (timed_out || n_wr != 2 || done_delta != 1) begin
            n_err++;
            $display("FAIL busy_start_count: writes=%0d done=%0d timeout=%0d, expected 2 1 0", n_wr, done_delta, timed_out);
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (wa[w_base + i] !== exp_a[i] || wd[w_base + i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL busy_start_word%0d: got %h/%h, expected %h/%h", i, wa[w_base + i], wd[w_base + i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         c;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            c = $urandom_range(1, 4);
            do_load(b, c, 0, -1, 0, -1, 1'b1);
            n_vec++;
            if (timed_out || n_wr != c || done_delta != 1) begin
                n_err++;
                $display("FAIL rand%0d_count: writes=%0d done=%0d timeout=%0d, expected %0d 1 0", k, n_wr, done_delta, timed_out, c);
            end
            for (int i = 0; i < c; i++) begin
                n_vec++;
                if (wa[w_base + i] !== exp_a[i] || wd[w_base + i] !== exp_d[i]) begin
                    n_err++;
                    $display("FAIL rand%0d_word%0d: got %h/%h, expected %h/%h", k, i, wa[w_base + i], wd[w_base + i], exp_a[i], exp_d[i]);
                end
            end
            n_vec++;
            if (verify_err !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_verify_err: got %b, expected 0", k, verify_err);
            end
        end
    endtask

    task automatic test_verify();
        int oe0 = oe_cnt;
        fault_en = 1'b1;
        do_load(8'h20, 4, 2, -1, 0, -1, 1'b0);
        fault_en = 1'b0;
        n_vec++;
        if (timed_out || n_wr != 4 || done_delta != 1) begin
            n_err++;
            $display("FAIL verify_count: writes=%0d done=%0d timeout=%0d, expected 4 1 0", n_wr, done_delta, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (wa[w_base + i] !== exp_a[i] || wd[w_base + i] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                n_err++;
                $display("FAIL verify_word%0d: got %h/%h, expected %h/ffffffffffffffff", i, wa[w_base + i], wd[w_base + i], exp_a[i]);
            end
        end
`ifdef MC_LOADER_VERIFY_EN
        n_vec++;
        if (verify_err !== 1'b1 || err_addr !== 8'h21) begin
            n_err++;
            $display("FAIL verify_flag: got %b/%h, expected 1/21", verify_err, err_addr);
        end
        n_vec++;
        if (oe_cnt == oe0) begin
            n_err++;
            $display("FAIL verify_oe: got 0 oe cycles, expected >0");
        end
`else
        n_vec++;
        if (verify_err !== 1'b0 || err_addr !== 8'h00) begin
            n_err++;
            $display("FAIL verify_off_flag: got %b/%h, expected 0/00", verify_err, err_addr);
        end
        n_vec++;
        if (oe_cnt != oe0) begin
            n_err++;
            $display("FAIL verify_off_oe: got %0d oe cycles, expected 0", oe_cnt - oe0);
        end
`endif
        do_load(8'h20, 1, 0, -1, 0, -1, 1'b0);
        n_vec++;
        if (verify_err !== 1'b0 || err_addr !== 8'h00 || n_wr != 1) begin
            n_err++;
            $display("FAIL verify_clear_on_start: got %b/%h n=%0d, expected 0/00 1", verify_err, err_addr, n_wr);
        end
    endtask

    initial begin
        _reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        byte_valid = 1'b0; byte_data = '0;
        test_reset();
        test_single_word();
        test_wraparound();
        test_host_stall();
        test_zero_count();
        test_busy_start();
        test_random();
        test_verify();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
